fifoc_cmd_parse: RTL and testbench

Command-frame parser downstream of the command FIFO (fifoc, written from the UDP receive path). On a start request it drains one received frame from the FIFO read port, checks header, length and checksum, and commits nine command bytes to registered outputs (kdev, smpr, filt, mix0, mix1, reg4..reg7). These outputs feed the ADC control logic. Frames that fail any check are discarded and flagged.

---
 rtl/fifoc_cmd_parse.sv | 101 ++++++++++
 tb/tb_fifoc_cmd_parse.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fifoc_cmd_parse.sv
// fifoc_cmd_parse: drains one command frame from fifoc, validates it and commits the command registers
module fifoc_cmd_parse #(
   parameter logic [7:0] HDR0      = 8'h55,
   parameter logic [7:0] HDR1      = 8'hAA,
   parameter int         FRAME_LEN = 12
) (
   input  logic        sys_clk,
   input  logic        rst,
   input  logic        fs,
   output logic        fd,
   input  logic [11:0] data_len,
   output logic        fifoc_rxen,
   input  logic [7:0]  fifoc_rxd,
   output logic [7:0]  cmd_kdev,
   output logic [7:0]  cmd_smpr,
   output logic [7:0]  cmd_filt,
   output logic [7:0]  cmd_mix0,
   output logic [7:0]  cmd_mix1,
   output logic [7:0]  cmd_reg4,
   output logic [7:0]  cmd_reg5,
   output logic [7:0]  cmd_reg6,
   output logic [7:0]  cmd_reg7,
   output logic        cmd_update,
   output logic        err
);
   typedef enum logic [1:0] {IDLE, READ, CHECK, DONE} state_t;
   state_t state, state_nx;
   logic [11:0] n, iss, cap;
   logic rd_v, hdr_ok, valid;
   logic [7:0] sum, csum;
   logic [0:8][7:0] shd;
   assign valid = (n == 12'(FRAME_LEN)) && hdr_ok && (csum == sum);
   // state register
   always_ff @(posedge sys_clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_nx;
   // next state and decoded outputs; READ ends once every read has been issued and the last byte is on rxd
   always_comb begin
      state_nx = state;
      fifoc_rxen = 1'b0;
      fd = 1'b0;
      cmd_update = 1'b0;
      case (state)
         IDLE: state_nx = fs ? READ : IDLE;
         READ: begin
            fifoc_rxen = iss != n;
            state_nx = (iss == n) ? CHECK : READ;
         end
         CHECK: begin
            cmd_update = valid;
            state_nx = DONE;
         end
         DONE: begin
            fd = 1'b1;
            state_nx = fs ? DONE : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end
   // frame length latch, read issue/capture counters, header/checksum tracking and payload shadows
   always_ff @(posedge sys_clk or posedge rst)
      if (rst) begin
         n <= '0;
         iss <= '0;
         cap <= '0;
         rd_v <= 1'b0;
         hdr_ok <= 1'b0;
         sum <= '0;
         csum <= '0;
         shd <= '0;
      end else begin
         rd_v <= fifoc_rxen;
         if (state == IDLE && fs) begin
            n <= data_len;
            iss <= '0;
            cap <= '0;
            hdr_ok <= 1'b1;
            sum <= '0;
         end else begin
            if (fifoc_rxen) iss <= iss + 12'd1;
            if (rd_v) begin
               cap <= cap + 12'd1;
               if (cap == 12'd0 && fifoc_rxd != HDR0) hdr_ok <= 1'b0;
               if (cap == 12'd1 && fifoc_rxd != HDR1) hdr_ok <= 1'b0;
               if (cap >= 12'd2 && cap <= 12'd10) sum <= sum + fifoc_rxd;
               for (int i = 0; i < 9; i++)
                  if (cap == 12'(i + 2)) shd[i] <= fifoc_rxd;
               if (cap == 12'd11) csum <= fifoc_rxd;
            end
         end
      end
   // commit shadows on a good frame, record the verdict of every frame
   always_ff @(posedge sys_clk or posedge rst)
      if (rst) begin
         {cmd_kdev, cmd_smpr, cmd_filt, cmd_mix0, cmd_mix1, cmd_reg4, cmd_reg5, cmd_reg6, cmd_reg7} <= '0;
         err <= 1'b0;
      end else if (state == CHECK) begin
         err <= !valid;
         if (valid) {cmd_kdev, cmd_smpr, cmd_filt, cmd_mix0, cmd_mix1, cmd_reg4, cmd_reg5, cmd_reg6, cmd_reg7} <= shd;
      end
endmodule

// File: tb/tb_fifoc_cmd_parse.sv
// tb_fifoc_cmd_parse: FIFO + timeline reference model, directed and random frames
module tb_fifoc_cmd_parse;
   logic sys_clk = 0, rst = 0, fs = 0;
   logic [11:0] data_len = 0;
   logic [7:0] fifoc_rxd = 0;
   logic fd, fifoc_rxen, cmd_update, err;
   logic [7:0] cmd_kdev, cmd_smpr, cmd_filt, cmd_mix0, cmd_mix1, cmd_reg4, cmd_reg5, cmd_reg6, cmd_reg7;
   logic [71:0] dut_cmd;
   int checks = 0, errors = 0, cyc = 0;
   int rx_cnt = 0, upd_cyc = -1, fd_cyc = -1, t0 = 0;
   logic [7:0] q[$];
   logic m_busy = 0, m_ok = 0, m_err = 0;
   int m_t0 = 0, m_n = 0;
   logic [71:0] m_pl = 0, m_cmd = 0;

   fifoc_cmd_parse dut (
      .sys_clk(sys_clk), .rst(rst), .fs(fs), .fd(fd), .data_len(data_len),
      .fifoc_rxen(fifoc_rxen), .fifoc_rxd(fifoc_rxd),
      .cmd_kdev(cmd_kdev), .cmd_smpr(cmd_smpr), .cmd_filt(cmd_filt), .cmd_mix0(cmd_mix0),
      .cmd_mix1(cmd_mix1), .cmd_reg4(cmd_reg4), .cmd_reg5(cmd_reg5), .cmd_reg6(cmd_reg6),
      .cmd_reg7(cmd_reg7), .cmd_update(cmd_update), .err(err)
   );
   assign dut_cmd = {cmd_kdev, cmd_smpr, cmd_filt, cmd_mix0, cmd_mix1, cmd_reg4, cmd_reg5, cmd_reg6, cmd_reg7};

   always #5 sys_clk = ~sys_clk;
   always @(posedge sys_clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // standard-mode FIFO: data appears one cycle after the read enable
   always @(posedge sys_clk)
      if (fifoc_rxen) begin
         if (q.size() == 0) chk("fifo_underflow", 72'd1, 72'd0);
         fifoc_rxd <= (q.size() != 0) ? q.pop_front() : 8'h00;
      end

   function automatic logic frame_ok(int len);
      int s = 0;
      if (len != 12 || q.size() < 12) return 1'b0;
      for (int i = 2; i <= 10; i++) s += int'(q[i]);
      return q[0] == 8'h55 && q[1] == 8'hAA && q[11] == 8'(s);
   endfunction

   function automatic logic [71:0] payload();
      logic [71:0] p = 0;
      for (int i = 2; i <= 10; i++) p = {p[63:0], (q.size() > i) ? q[i] : 8'h00};
      return p;
   endfunction

   // reference timeline: frame latched at t0, reads t0..t0+N-1, verdict at t0+N+1, done from t0+N+2
   always @(posedge sys_clk or posedge rst)
      if (rst) begin
         m_busy <= 0;
         m_cmd <= 0;
         m_err <= 0;
      end else if (!m_busy) begin
         if (fs) begin
            m_busy <= 1;
            m_t0 <= cyc + 1;
            m_n <= int'(data_len);
            m_ok <= frame_ok(int'(data_len));
            m_pl <= payload();
         end
      end else if (cyc == m_t0 + m_n + 1) begin
         m_err <= !m_ok;
         if (m_ok) m_cmd <= m_pl;
      end else if (cyc >= m_t0 + m_n + 2 && !fs) m_busy <= 0;

   always @(negedge sys_clk)
      if (!rst) begin
         chk("rxen", 72'(fifoc_rxen), 72'(m_busy && cyc >= m_t0 && cyc < m_t0 + m_n));
         chk("cmd_update", 72'(cmd_update), 72'(m_busy && cyc == m_t0 + m_n + 1 && m_ok));
         chk("fd", 72'(fd), 72'(m_busy && cyc >= m_t0 + m_n + 2));
         chk("err", 72'(err), 72'(m_err));
         chk("cmd", dut_cmd, m_cmd);
         if (fifoc_rxen) rx_cnt++;
         if (cmd_update && upd_cyc < 0) upd_cyc = cyc;
         if (fd && fd_cyc < 0) fd_cyc = cyc;
      end

   task automatic push_frame(input logic [71:0] pl, input logic [7:0] h0, input logic [7:0] dcs);
      int s = 0;
      q.push_back(h0);
      q.push_back(8'hAA);
      for (int i = 8; i >= 0; i--) begin
         q.push_back(pl[i*8+:8]);
         s += int'(pl[i*8+:8]);
      end
      q.push_back(8'(s) + dcs);
   endtask

   task automatic run(input int len, input int hold);
      rx_cnt = 0;
      upd_cyc = -1;
      fd_cyc = -1;
      @(posedge sys_clk);
      #1 fs = 1;
      data_len = 12'(len);
      @(posedge sys_clk);
      #1 t0 = cyc;
      data_len = 12'($urandom);
      repeat (hold) @(posedge sys_clk);
      #1 fs = 0;
      repeat (len + 6) @(posedge sys_clk);
      #1 chk("drained", 72'(q.size()), 72'd0);
      chk("idle_fd", 72'(fd), 72'd0);
   endtask

   task automatic chk_zero(input string nm);
      chk(nm, {dut_cmd, fd, fifoc_rxen, cmd_update, err}, 72'd0);
   endtask

   initial begin
      #1 rst = 1;
      #2 chk_zero("reset_outputs");
      repeat (3) @(posedge sys_clk);
      #1 rst = 0;
      // bad checksum first: commands stay at reset value
      push_frame(72'h010203040506070809, 8'h55, 8'hFF);
      run(12, 20);
      chk("badcs_err", 72'(err), 72'd1);
      chk("badcs_cmd", dut_cmd, 72'd0);
      chk("badcs_noupd", 72'(upd_cyc), 72'(-1));
      chk("badcs_fd_lat", 72'(fd_cyc - t0), 72'd14);
      // valid frame 55 AA 01..09 2D
      push_frame(72'h010203040506070809, 8'h55, 8'h00);
      run(12, 20);
      chk("valid_rxcnt", 72'(rx_cnt), 72'd12);
      chk("valid_upd_lat", 72'(upd_cyc - t0), 72'd13);
      chk("valid_fd_lat", 72'(fd_cyc - t0), 72'd14);
      chk("valid_cmd", dut_cmd, 72'h010203040506070809);
      chk("valid_err", 72'(err), 72'd0);
      // bad header
      push_frame(72'h0A0B0C0D0E0F101112, 8'h54, 8'h00);
      run(12, 15);
      chk("badhdr_err", 72'(err), 72'd1);
      chk("badhdr_cmd", dut_cmd, 72'h010203040506070809);
      // wrong length: valid frame plus two trailing bytes
      push_frame(72'h111213141516171819, 8'h55, 8'h00);
      q.push_back(8'h77);
      q.push_back(8'h88);
      run(14, 3);
      chk("len_rxcnt", 72'(rx_cnt), 72'd14);
      chk("len_err", 72'(err), 72'd1);
      push_frame(72'h111213141516171819, 8'h55, 8'h00);
      run(12, 16);
      chk("follow_cmd", dut_cmd, 72'h111213141516171819);
      chk("follow_err", 72'(err), 72'd0);
      // zero length
      run(0, 6);
      chk("zero_rxcnt", 72'(rx_cnt), 72'd0);
      chk("zero_err", 72'(err), 72'd1);
      chk("zero_fd_lat", 72'(fd_cyc - t0), 72'd2);
      // asynchronous reset after five reads
      push_frame(72'h212223242526272829, 8'h55, 8'h00);
      @(posedge sys_clk);
      #1 fs = 1;
      data_len = 12'd12;
      @(posedge sys_clk);
      repeat (5) @(posedge sys_clk);
      #2 rst = 1;
      #1 chk_zero("midread_reset");
      q.delete();
      fs = 0;
      @(posedge sys_clk);
      #1 rst = 0;
      push_frame(72'h313233343536373839, 8'h55, 8'h00);
      run(12, 14);
      chk("post_reset_cmd", dut_cmd, 72'h313233343536373839);
      chk("post_reset_rxcnt", 72'(rx_cnt), 72'd12);
      // random frames
      for (int k = 0; k < 60; k++) begin
         int kind, len;
         logic [71:0] pl;
         kind = $urandom_range(0, 3);
         pl = {$urandom, $urandom, $urandom};
         len = 12;
         if (kind == 0) push_frame(pl, 8'h55, 8'h00);
         else if (kind == 1) push_frame(pl, 8'h55, 8'($urandom_range(1, 255)));
         else if (kind == 2) push_frame(pl, 8'h55 ^ 8'($urandom_range(1, 255)), 8'h00);
         else begin
            len = $urandom_range(0, 16);
            if (len >= 12) begin
               push_frame(pl, 8'h55, 8'h00);
               for (int j = 12; j < len; j++) q.push_back(8'($urandom));
            end else
               for (int j = 0; j < len; j++) q.push_back(8'($urandom));
         end
         run(len, $urandom_range(0, len + 8));
         chk("rand_rxcnt", 72'(rx_cnt), 72'(len));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
